// File: rtl/apb_cmd_master.sv
// apb_cmd_master: queues read/write commands and issues them one at a time as
// two-phase APB transfers, returning one in-order response per command.
module apb_cmd_master #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned CMD_DEPTH   = 4,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] PADDR_M,
   output logic                  PWRITE_M,
   output logic                  PSEL_M,
   output logic                  PENABLE_M,
   output logic [DATA_WIDTH-1:0] PWDATA_M,
   input  logic [DATA_WIDTH-1:0] PRDATA_M,
   input  logic                  PREADY_M,
   input  logic                  PSLVERR_M
);

   localparam int unsigned PTR_W     = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam int unsigned WAIT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned WAIT_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   cmd_t                  mem [CMD_DEPTH];
   cmd_t                  head;
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_nxt;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  timeout_hit;

   state_t                state_q;
   state_t                state_nxt;
   logic [WAIT_W-1:0]     wait_q;
   logic [WAIT_W-1:0]     wait_nxt;

   logic                  psel_nxt;
   logic                  penable_nxt;
   logic                  pwrite_nxt;
   logic [ADDR_WIDTH-1:0] paddr_nxt;
   logic [DATA_WIDTH-1:0] pwdata_nxt;
   logic                  rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
   logic                  rsp_err_nxt;
   logic                  rsp_timeout_nxt;
   logic                  busy_nxt;

   // FIFO status; a full FIFO refuses even when a pop is happening this cycle
   assign full        = (count_q == CNT_W'(CMD_DEPTH));
   assign empty       = (count_q == '0);
   assign cmd_ready   = !full && !PRESET;
   assign push        = cmd_valid && cmd_ready;
   assign head        = mem[rd_ptr_q];
   assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_q == WAIT_W'(WAIT_LAST));

   // next-state, pop decision and next values of every registered output
   always_comb begin
      state_nxt       = state_q;
      wait_nxt        = wait_q;
      pop             = 1'b0;
      psel_nxt        = PSEL_M;
      penable_nxt     = PENABLE_M;
      pwrite_nxt      = PWRITE_M;
      paddr_nxt       = PADDR_M;
      pwdata_nxt      = PWDATA_M;
      rsp_valid_nxt   = rsp_valid;
      rsp_rdata_nxt   = rsp_rdata;
      rsp_err_nxt     = rsp_err;
      rsp_timeout_nxt = rsp_timeout;
      count_nxt       = count_q;

      unique case (state_q)
         IDLE: begin
            if (!empty) pop = 1'b1;
         end
         SETUP: begin
            penable_nxt = 1'b1;
            state_nxt   = ACCESS;
         end
         ACCESS: begin
            if (PREADY_M) begin
               rsp_rdata_nxt   = PWRITE_M ? '0 : PRDATA_M;
               rsp_err_nxt     = PSLVERR_M;
               rsp_timeout_nxt = 1'b0;
               rsp_valid_nxt   = 1'b1;
               psel_nxt        = 1'b0;
               penable_nxt     = 1'b0;
               state_nxt       = RESP;
            end else if (timeout_hit) begin
               rsp_rdata_nxt   = '0;
               rsp_err_nxt     = 1'b1;
               rsp_timeout_nxt = 1'b1;
               rsp_valid_nxt   = 1'b1;
               psel_nxt        = 1'b0;
               penable_nxt     = 1'b0;
               state_nxt       = RESP;
            end else begin
               wait_nxt = wait_q + WAIT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               if (!empty) pop = 1'b1;
               else        state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // launching a command: load the APB fields and enter SETUP
      if (pop) begin
         psel_nxt    = 1'b1;
         penable_nxt = 1'b0;
         pwrite_nxt  = head.write;
         paddr_nxt   = head.addr;
         pwdata_nxt  = head.wdata;
         wait_nxt    = '0;
         state_nxt   = SETUP;
      end

      unique case ({push, pop})
         2'b10:   count_nxt = count_q + CNT_W'(1);
         2'b01:   count_nxt = count_q - CNT_W'(1);
         default: count_nxt = count_q;
      endcase

      busy_nxt = (count_nxt != '0) || (state_nxt != IDLE);
   end

   // state, pointers and registered outputs
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         PSEL_M      <= 1'b0;
         PENABLE_M   <= 1'b0;
         PWRITE_M    <= 1'b0;
         PADDR_M     <= '0;
         PWDATA_M    <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         wait_q      <= wait_nxt;
         count_q     <= count_nxt;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         PSEL_M      <= psel_nxt;
         PENABLE_M   <= penable_nxt;
         PWRITE_M    <= pwrite_nxt;
         PADDR_M     <= paddr_nxt;
         PWDATA_M    <= pwdata_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
         rsp_err     <= rsp_err_nxt;
         rsp_timeout <= rsp_timeout_nxt;
         busy        <= busy_nxt;
      end
   end

   // command storage; contents are don't-care while the FIFO is empty
   always_ff @(posedge PCLK) begin
      if (push) mem[wr_ptr_q] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
   end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Upstream APB master that drives the PD0 APB bus master port (PADDR_M..PSLVERR_M).
- Accepts read/write commands from a simple valid/ready command stream and queues them in a small FIFO.
- Issues the commands as compliant two-phase APB transfers, one at a time, in order.
- Returns one response per command (read data, slave error, timeout flag) on a valid/ready response stream.
- Serves as the single bus master for the AON regfile, power controller, AON timer and BOD slaves.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- CMD_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYC, 64, consecutive ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  Clock.
- PRESET  in  1  Reset; synchronous, active-high.
- cmd_valid  in  1  Command offered.
- cmd_ready  out  1  Command FIFO can accept.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  Target address.
- cmd_wdata  in  DATA_WIDTH  Write data.
- rsp_valid  out  1  Response available.
- rsp_ready  in  1  Response consumed.
- rsp_rdata  out  DATA_WIDTH  Read data.
- rsp_err  out  1  PSLVERR or timeout.
- rsp_timeout  out  1  Transfer aborted by timeout.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- PADDR_M  out  ADDR_WIDTH  APB address.
- PWRITE_M  out  1  APB write.
- PSEL_M  out  1  APB select.
- PENABLE_M  out  1  APB enable.
- PWDATA_M  out  DATA_WIDTH  APB write data.
- PRDATA_M  in  DATA_WIDTH  APB read data.
- PREADY_M  in  1  APB ready.
- PSLVERR_M  in  1  APB slave error.

Behaviour:
- Reset: sampled only at a PCLK edge. Every output is 0 while PRESET is high, including cmd_ready. The FIFO is emptied, the FSM goes to IDLE, and the timeout counter is cleared.
- Reset mid-transfer: PSEL_M and PENABLE_M drop at the reset edge. In-flight and queued commands are discarded and no response is produced.
- FIFO:
  - cmd_ready = !full && !PRESET.
  - A push occurs when cmd_valid && cmd_ready.
  - There is no bypass path, and a full FIFO never accepts a command even if a pop happens in the same cycle.
  - Pointers wrap modulo CMD_DEPTH.
  - The FIFO is popped on IDLE->SETUP and on RESP->SETUP.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head, register PADDR_M/PWRITE_M/PWDATA_M, set PSEL_M=1, and go to SETUP.
  - Latency: a command pushed into an empty FIFO in idle cycle t gives PSEL_M=1 in cycle t+2.
- SETUP: set PENABLE_M=1 and go to ACCESS unconditionally (exactly one cycle).
- ACCESS, when PREADY_M=1:
  - Capture rsp_rdata = PRDATA_M for reads (0 for writes) and rsp_err = PSLVERR_M; set rsp_timeout=0.
  - Drop PSEL_M and PENABLE_M, and go to RESP.
  - PSLVERR_M is ignored when PREADY_M=0.
- ACCESS, when PREADY_M=0: increment the wait counter.
  - If TIMEOUT_CYC>0 and this is the TIMEOUT_CYC-th consecutive low cycle, abort: drop PSEL_M/PENABLE_M, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, and go to RESP.
  - PREADY_M=1 on the TIMEOUT_CYC-th cycle completes the transfer normally.
- RESP:
  - rsp_valid=1, with rsp_* held stable until rsp_ready.
  - On handshake, go to SETUP (popping the next command) if the FIFO is non-empty; otherwise go to IDLE.
  - The counter clears on every SETUP entry.
- APB output rules:
  - PADDR_M, PWRITE_M and PWDATA_M hold from SETUP through the end of ACCESS, and keep their last value afterwards.
  - PSEL_M and PENABLE_M are registered and are never 1 outside SETUP/ACCESS.
- At most one APB transfer is outstanding. Responses are returned in command order.
- busy is a registered OR of FIFO non-empty and FSM != IDLE.

Test Plan:
- Single write: push write, addr 0x0000_0010, data 0xDEAD_BEEF, slave PREADY=1 immediately -> PSEL_M high 2 cycles after push, PENABLE_M high the next cycle, rsp_valid=1 with rsp_err=0 and rsp_rdata=0.
- Read with wait states: push read, addr 0x0000_0004, PREADY low for 3 ACCESS cycles then high with PRDATA=0x1234_5678 -> PENABLE_M high for 4 cycles, address stable throughout, rsp_rdata=0x1234_5678.
- Backpressure and full FIFO: hold rsp_ready=0 and push 6 commands -> cmd_ready=0 after 4 queued plus 1 in flight. Release rsp_ready -> 5 responses in order, with back-to-back RESP->SETUP and no IDLE cycle.
- Slave error: PSLVERR=1 with PREADY=1 on a write -> rsp_err=1, rsp_timeout=0. PSLVERR=1 while PREADY=0 -> ignored.
- Timeout: TIMEOUT_CYC=8, PREADY stuck low -> abort after the 8th ACCESS cycle, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY=1 on the 8th cycle -> normal completion.
- Reset mid-ACCESS with 2 commands queued -> PSEL_M=0 and cmd_ready=0 at the reset edge, no rsp_valid, busy=0, FIFO empty after release.
